br_resolve_unit: RTL and testbench

//  Pipelined branch resolution unit for the EX stage. It evaluates conditional

---
 rtl/br_resolve_unit.sv | 190 +++++++++++++++++++
 tb/tb_br_resolve_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
// Branch resolution unit: evaluates conditional branches and jumps, compares the
// outcome against the front-end prediction, redirects on mispredict and squashes younger ops.
module br_resolve_unit #(
    parameter int DW     = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      ctr,
    input  logic [DW-1:0]    pc,
    input  logic [DW-1:0]    imm,
    input  logic [DW-1:0]    rrj,
    input  logic [DW-1:0]    alu1,
    input  logic [DW-1:0]    alu2,
    input  logic             pdc_taken,
    input  logic [DW-1:0]    pdc_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_taken,
    output logic [DW-1:0]    br_target,
    output logic             redirect,
    output logic [DW-1:0]    redirect_pc,
    input  logic             redirect_ack,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic          is_br;
        logic          taken;
        logic          mispred;
        logic [DW-1:0] target;
        logic [DW-1:0] rpc;
    } res_t;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t           state_reg;
    res_t             res_comb;
    logic             cond;
    logic [3:0]       br_type;
    logic [4:0]       br_sub;
    logic             advance;
    logic             enter_squash;
    logic             redirect_reg;
    logic [CNT_W-1:0] cnt_branch_reg;
    logic [CNT_W-1:0] cnt_mispred_reg;

    logic stage_valid [STAGES];
    res_t stage_data  [STAGES];
    logic link_valid  [STAGES];
    res_t link_data   [STAGES];

    // Control-word fields this unit does not interpret.
    logic unused_ctr;
    assign unused_ctr = ^{ctr[31:12], ctr[6:4]};

    assign br_type = ctr[3:0];
    assign br_sub  = ctr[11:7];

    always_comb begin
        cond = 1'b0;
        case (br_sub)
            5'd0:    cond = 1'b1;
            5'd1:    cond = (alu1 == alu2);
            5'd2:    cond = (alu1 != alu2);
            5'd3:    cond = ($signed(alu1) <  $signed(alu2));
            5'd4:    cond = ($signed(alu1) >= $signed(alu2));
            5'd5:    cond = (alu1 <  alu2);
            5'd6:    cond = (alu1 >= alu2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        res_comb        = '0;
        res_comb.target = pc + imm;
        if (br_type == 4'd1) begin
            res_comb.is_br = 1'b1;
            res_comb.taken = cond;
        end else if (br_type == 4'd8) begin
            res_comb.is_br = 1'b1;
            res_comb.taken = 1'b1;
            if (br_sub == 5'd0)
                res_comb.target = rrj + imm;
        end
        res_comb.rpc     = res_comb.taken ? res_comb.target : pc + DW'(4);
        res_comb.mispred = res_comb.is_br &
                           ((res_comb.taken != pdc_taken) |
                            (res_comb.taken & (res_comb.target != pdc_target)));
    end

    // The whole pipe moves as one: it stalls only while the output holds an unaccepted result.
    assign advance      = ~stage_valid[LAST] | out_ready;
    assign in_ready     = (state_reg == SQUASH) | advance;
    assign enter_squash = (state_reg == RUN) & advance & link_valid[LAST] & link_data[LAST].mispred;

    assign link_valid[0] = in_valid & advance & (state_reg == RUN);
    assign link_data[0]  = res_comb;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi > 0) begin : g_link
                assign link_valid[gi] = stage_valid[gi-1];
                assign link_data[gi]  = stage_data[gi-1];
            end

            if (gi < LAST) begin : g_mid
                logic valid_reg;
                res_t data_reg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else if ((state_reg == SQUASH) || enter_squash) begin
                        valid_reg <= 1'b0;
                    end else if (advance) begin
                        valid_reg <= link_valid[gi];
                        if (link_valid[gi])
                            data_reg <= link_data[gi];
                    end
                end
                assign stage_valid[gi] = valid_reg;
                assign stage_data[gi]  = data_reg;
            end else begin : g_out
                logic valid_reg;
                res_t data_reg;
                // A mispredicting op still leaves through the output; only younger ops are dropped.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_reg    <= 1'b0;
                        data_reg     <= '0;
                        redirect_reg <= 1'b0;
                    end else begin
                        redirect_reg <= 1'b0;
                        if (state_reg == SQUASH) begin
                            if (out_ready)
                                valid_reg <= 1'b0;
                        end else if (advance) begin
                            valid_reg    <= link_valid[gi];
                            redirect_reg <= enter_squash;
                            if (link_valid[gi])
                                data_reg <= link_data[gi];
                        end
                    end
                end
                assign stage_valid[gi] = valid_reg;
                assign stage_data[gi]  = data_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN:     if (enter_squash) state_reg <= SQUASH;
                SQUASH:  if (redirect_ack) state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_branch_reg  <= '0;
            cnt_mispred_reg <= '0;
        end else begin
            if (stage_valid[LAST] && out_ready && stage_data[LAST].is_br && (cnt_branch_reg != '1))
                cnt_branch_reg <= cnt_branch_reg + 1'b1;
            if (redirect_reg && (cnt_mispred_reg != '1))
                cnt_mispred_reg <= cnt_mispred_reg + 1'b1;
        end
    end

    assign out_valid   = stage_valid[LAST];
    assign br_taken    = stage_data[LAST].taken;
    assign br_target   = stage_data[LAST].target;
    assign redirect_pc = stage_data[LAST].rpc;
    assign redirect    = redirect_reg;
    assign cnt_branch  = cnt_branch_reg;
    assign cnt_mispred = cnt_mispred_reg;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit (two-stage build): directed ops push expected
// results, an independent monitor pops and compares at every output transfer.
module tb_br_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ctr = '0, pc = '0, imm = '0, rrj = '0, alu1 = '0, alu2 = '0;
    logic        pdc_taken = 1'b0;
    logic [31:0] pdc_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_ack = 1'b0;
    logic [31:0] cnt_branch, cnt_mispred;

    br_resolve_unit #(.DW(32), .STAGES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctr(ctr),
        .pc(pc), .imm(imm), .rrj(rrj), .alu1(alu1), .alu2(alu2),
        .pdc_taken(pdc_taken), .pdc_target(pdc_target), .out_valid(out_valid),
        .out_ready(out_ready), .br_taken(br_taken), .br_target(br_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        red;
        logic [31:0] rpc;
        logic        chk_tgt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;
    int   exp_br = 0;
    int   exp_mp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples 2ns after the falling edge, when inputs driven on that edge have settled.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (redirect && !out_valid) begin
                checks++;
                failures++;
                $display("FAIL redirect_without_valid actual=1 required=0");
            end
            if (out_valid && out_ready) begin
                exp_t e;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output taken=%0b target=%0h", br_taken, br_target);
                end else begin
                    e = q.pop_front();
                    txn++;
                    $display("txn %0d: taken=%0b target=%0h redirect=%0b rpc=%0h", txn, br_taken, br_target, redirect, redirect_pc);
                    if (br_taken !== e.taken || redirect !== e.red ||
                        (e.chk_tgt && (br_target !== e.target || redirect_pc !== e.rpc))) begin
                        failures++;
                        $display("FAIL txn%0d actual=%0b/%0h/%0b/%0h required=%0b/%0h/%0b/%0h",
                                 txn, br_taken, br_target, redirect, redirect_pc,
                                 e.taken, e.target, e.red, e.rpc);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one op; when push is set the expected response goes to the scoreboard.
    task automatic send(input logic [31:0] c, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] rj, input logic [31:0] a1, input logic [31:0] a2,
                        input logic pt, input logic [31:0] ptg, input logic push,
                        input logic et, input logic [31:0] etg, input logic er,
                        input logic [31:0] erp, input logic ct);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        ctr = c; pc = p; imm = im; rrj = rj; alu1 = a1; alu2 = a2;
        pdc_taken = pt; pdc_target = ptg; in_valid = 1'b1;
        if (push) begin
            e.taken = et; e.target = etg; e.red = er; e.rpc = erp; e.chk_tgt = ct;
            q.push_back(e);
        end
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        redirect_ack = 1'b1;
        @(negedge clk);
        redirect_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_br_target", br_target, 32'd0);
        chk("rst_cnt_branch", cnt_branch, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(2);

        // 1: beq taken, correctly predicted
        send(32'h81, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 1'b1, 32'h120, 1'b0, 32'h120, 1'b1);
        exp_br++;
        wait_cycles(4);
        chk("t1_cnt_branch", cnt_branch, exp_br);

        // 2: bltu not taken, predicted taken -> redirect to pc+4
        send(32'h281, 32'h200, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h240, 1'b1, 1'b0, 32'h240, 1'b1, 32'h204, 1'b1);
        exp_br++; exp_mp++;
        wait_cycles(4);
        chk("t2_cnt_mispred", cnt_mispred, exp_mp);
        chk("t2_cnt_branch", cnt_branch, exp_br);
        ack_pulse();
        ack_pulse();  // ack while already running: ignored

        // 3: jirl to rrj+imm mispredicted; younger ops dropped until ack
        send(32'h8, 32'h300, 32'h8, 32'h2000, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h2008, 1'b1, 32'h2008, 1'b1);
        exp_br++; exp_mp++;
        wait_cycles(4);
        for (int i = 0; i < 3; i++)
            send(32'h81, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        ctr = 32'h81; pc = 32'h100; imm = 32'h20; alu1 = 32'd5; alu2 = 32'd5;
        pdc_taken = 1'b1; pdc_target = 32'h120; in_valid = 1'b1; redirect_ack = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; redirect_ack = 1'b0;
        wait_cycles(4);
        chk("t3_cnt_branch_after_drop", cnt_branch, exp_br);
        chk("t3_cnt_mispred", cnt_mispred, exp_mp);
        send(32'h81, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 1'b1, 32'h120, 1'b0, 32'h120, 1'b1);
        exp_br++;
        wait_cycles(4);
        chk("t3_cnt_branch_resume", cnt_branch, exp_br);

        // 4: output back-pressure holds fields and blocks input
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h81, 32'h500, 32'h30, 32'h0, 32'd7, 32'd7, 1'b1, 32'h530, 1'b1, 1'b1, 32'h530, 1'b0, 32'h530, 1'b1);
        exp_br++;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_out_valid_arrives", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_target", br_target, 32'h530);
            chk("t4_hold_taken", {31'd0, br_taken}, 32'd1);
            chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        wait_cycles(3);
        chk("t4_cnt_branch", cnt_branch, exp_br);

        // 5: compare variants, jump with pc+imm wrap, non-branch op
        send(32'h181, 32'h400, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h410, 1'b1, 1'b1, 32'h410, 1'b0, 32'h410, 1'b1);
        send(32'h201, 32'h400, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h410, 1'b0, 32'h404, 1'b1);
        send(32'h3,   32'h400, 32'h10, 32'h0, 32'h0, 32'h0,          1'b1, 32'h410, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        send(32'h101, 32'h600, 32'h8,  32'h0, 32'd1, 32'd2,          1'b1, 32'h608, 1'b1, 1'b1, 32'h608, 1'b0, 32'h608, 1'b1);
        send(32'h301, 32'h700, 32'h4,  32'h0, 32'd1, 32'hFFFF_FFFF,  1'b0, 32'h0,   1'b1, 1'b0, 32'h704, 1'b0, 32'h704, 1'b1);
        send(32'h481, 32'h800, 32'h10, 32'h0, 32'd3, 32'd3,          1'b0, 32'h0,   1'b1, 1'b0, 32'h810, 1'b0, 32'h804, 1'b1);
        send(32'h88,  32'hFFFF_FFF0, 32'h20, 32'h5000, 32'h0, 32'h0, 1'b1, 32'h10,  1'b1, 1'b1, 32'h10,  1'b0, 32'h10,  1'b1);
        send(32'h1,   32'h900, 32'h100, 32'h0, 32'd1, 32'd9,         1'b1, 32'hA00, 1'b1, 1'b1, 32'hA00, 1'b0, 32'hA00, 1'b1);
        exp_br += 7;
        wait_cycles(5);
        chk("t5_cnt_branch", cnt_branch, exp_br);
        chk("t5_cnt_mispred", cnt_mispred, exp_mp);

        // 6: asynchronous reset while squashing
        send(32'h8, 32'h300, 32'h8, 32'h2000, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h2008, 1'b1, 32'h2008, 1'b1);
        exp_br++; exp_mp++;
        wait_cycles(4);
        send(32'h81, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        send(32'h81, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_pre_cnt_mispred", cnt_mispred, exp_mp);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_br_target", br_target, 32'd0);
        chk("t6_rst_redirect_pc", redirect_pc, 32'd0);
        chk("t6_rst_br_taken", {31'd0, br_taken}, 32'd0);
        chk("t6_rst_cnt_branch", cnt_branch, 32'd0);
        chk("t6_rst_cnt_mispred", cnt_mispred, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_br = 0; exp_mp = 0;
        @(negedge clk);
        rst = 1'b0;
        send(32'h81, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 1'b1, 32'h120, 1'b0, 32'h120, 1'b1);
        exp_br++;
        wait_cycles(4);
        chk("t6_run_after_rst_cnt", cnt_branch, exp_br);
        chk("t6_cnt_mispred_after", cnt_mispred, exp_mp);

        wait_cycles(3);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
